// File: rtl/gf13_pkg.sv
// GF(2^13) field constants, constant-power multiply helper and Chien FSM states.
// Latency: none (package only).
// Backpressure: not applicable.
package gf13_pkg;

    localparam int GF_M     = 13;
    localparam int GF_ORDER = 8191;
    // x^13 + x^4 + x^3 + x + 1
    localparam logic [GF_M:0] GF_PRIM_POLY = 14'h201B;

    // a * alpha^pow, built as repeated multiply-by-x with reduction; with a
    // constant pow this folds into a pure XOR matrix.
    function automatic logic [GF_M-1:0] gf_mul_const(input logic [GF_M-1:0] a, input int pow);
        logic [GF_M-1:0] r;
        r = a;
        for (int k = 0; k < pow; k++) begin
            r = {r[GF_M-2:0], 1'b0} ^ (r[GF_M-1] ? GF_PRIM_POLY[GF_M-1:0] : '0);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chien_state_t;

endpackage

// File: rtl/gf13_const_mul.sv
// Constant multiplier c = a * alpha^POW over GF(2^13).
// Latency: combinational.
// Backpressure: none; pure XOR network.
module gf13_const_mul
    import gf13_pkg::*;
#(
    parameter int POW = 1
) (
    input  logic [GF_M-1:0] a,
    output logic [GF_M-1:0] c
);

    assign c = gf_mul_const(a, POW);

endmodule

// File: rtl/bch_chien_ctrl.sv
// Chien search sequencer: loads sigma(x), evaluates sigma(alpha^j) per position, checks root count.
// Latency: first result 1 cycle after start; 1 position/cycle; done after N_LEN transfers.
// Backpressure: out_valid/out_ready; on stall all registers and out_idx/out_err hold.
module bch_chien_ctrl
    import gf13_pkg::*;
#(
    parameter int T     = 8,
    parameter int N_LEN = GF_ORDER
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(T+1)*GF_M-1:0] sigma_in,
    input  logic [3:0]            deg_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err,
    output logic [12:0]           out_idx,
    output logic                  done,
    output logic                  fail,
    output logic [4:0]            root_cnt
);

    localparam logic [12:0] LAST_IDX = 13'(N_LEN - 1);

    chien_state_t    state_q, state_d;
    logic [GF_M-1:0] coef_q   [0:T];
    logic [GF_M-1:0] coef_nxt [1:T];
    logic [GF_M-1:0] sum;
    logic [3:0]      deg_q;
    logic [4:0]      root_cnt_inc;
    logic            zero_hit;
    logic            xfer;
    logic            last_pos;

    // Coefficient i advances by alpha^i per step; sigma_0 never changes.
    for (genvar i = 1; i <= T; i++) begin : g_mul
        gf13_const_mul #(.POW(i)) u_mul (
            .a (coef_q[i]),
            .c (coef_nxt[i])
        );
    end

    // Sum of all terms is sigma(alpha^j) for the current step.
    always_comb begin
        sum = '0;
        for (int i = 0; i <= T; i++) begin
            sum = sum ^ coef_q[i];
        end
    end

    assign zero_hit     = (sum == '0);
    assign out_err      = out_valid & zero_hit;
    assign xfer         = out_valid & out_ready;
    assign last_pos     = (out_idx == LAST_IDX);
    assign root_cnt_inc = (root_cnt == 5'd31) ? 5'd31 : root_cnt + {4'd0, zero_hit};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (xfer && last_pos) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Load on start, step on each accepted position; verdict taken on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= T; i++) begin
                coef_q[i] <= '0;
            end
            deg_q    <= '0;
            out_idx  <= '0;
            root_cnt <= '0;
            fail     <= 1'b0;
        end else if (state_q == IDLE && start) begin
            for (int i = 0; i <= T; i++) begin
                coef_q[i] <= sigma_in[i*GF_M +: GF_M];
            end
            deg_q    <= deg_in;
            out_idx  <= '0;
            root_cnt <= '0;
            fail     <= 1'b0;
        end else if (xfer) begin
            for (int i = 1; i <= T; i++) begin
                coef_q[i] <= coef_nxt[i];
            end
            root_cnt <= root_cnt_inc;
            if (last_pos) begin
                fail <= (root_cnt_inc != {1'b0, deg_q});
            end else begin
                out_idx <= out_idx + 13'd1;
            end
        end
    end

endmodule

// File: tb/tb_bch_chien_ctrl.sv
// Self-checking bench for bch_chien_ctrl against a log/antilog polynomial evaluator.
// Latency: not applicable.
// Backpressure: bench drives out_ready (tied high, fixed stall, or random).
module tb_bch_chien_ctrl;

    localparam int M     = 13;
    localparam int T     = 8;
    localparam int N_LEN = 8191;
    localparam int NZ    = 8191;
    localparam int SW    = (T + 1) * M;
    localparam int LIMIT = 20000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [SW-1:0] sigma_in  = '0;
    logic [3:0]    deg_in    = '0;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          out_valid;
    logic          out_err;
    logic [12:0]   out_idx;
    logic          done;
    logic          fail;
    logic [4:0]    root_cnt;

    bch_chien_ctrl #(.T(T), .N_LEN(N_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sigma_in  (sigma_in),
        .deg_in    (deg_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err),
        .out_idx   (out_idx),
        .done      (done),
        .fail      (fail),
        .root_cnt  (root_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int alog  [NZ];
    int log_t [NZ + 1];
    int exp_q [$];

    int         obs_err [$];
    int         obs_xfers, obs_seq_bad, obs_run_cycles, obs_stalls;
    int         obs_hold_bad, obs_busy_bad, obs_gap;
    bit         obs_done, obs_timeout, obs_first_ok, obs_aborted;
    bit         obs_after_ok, obs_busy_done, obs_rst_zero;
    logic [4:0] obs_root;
    logic       obs_fail;

    task automatic init_tables();
        int v;
        v = 1;
        for (int e = 0; e < NZ; e++) begin
            alog[e]  = v;
            log_t[v] = e;
            v = v << 1;
            if ((v & 32'h2000) != 0) v = v ^ 32'h201B;
        end
    endtask

    function automatic int gf_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return alog[(log_t[a] + log_t[b]) % NZ];
    endfunction

    // sigma(x) = scalar * prod (1 + alpha^-r x): roots at alpha^r.
    task automatic build_sigma(input int roots[$], input int scalar, output logic [SW-1:0] s);
        int p [T+1];
        int inv;
        for (int i = 0; i <= T; i++) p[i] = 0;
        p[0] = scalar;
        foreach (roots[k]) begin
            inv = alog[(NZ - roots[k]) % NZ];
            for (int i = T; i >= 1; i--) p[i] = p[i] ^ gf_mul(inv, p[i-1]);
        end
        s = '0;
        for (int i = 0; i <= T; i++) s[i*M +: M] = 13'(p[i]);
    endtask

    // Direct evaluation of sigma(alpha^j) for every position.
    task automatic model_roots(input logic [SW-1:0] s);
        int acc, c;
        exp_q.delete();
        for (int j = 0; j < N_LEN; j++) begin
            acc = 0;
            for (int i = 0; i <= T; i++) begin
                c = int'(s[i*M +: M]);
                if (c != 0) acc = acc ^ alog[(log_t[c] + i * j) % NZ];
            end
            if (acc == 0) exp_q.push_back(j);
        end
    endtask

    function automatic bit same_list(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[k]) if (a[k] != b[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_of(input int a[$]);
        return (a.size() > 0) ? a[0] : -1;
    endfunction

    // mode 0: ready high; 1: stall stall_len cycles at stall_idx; 2: random ready.
    task automatic run_search(input logic [SW-1:0] sig, input logic [3:0] deg, input int mode,
                              input int stall_idx, input int stall_len, input int busy_idx,
                              input int rst_idx);
        int          cyc, stall_left;
        bit          finished, prev_hold, pulsed, rdy;
        logic [12:0] prev_idx;
        logic        prev_err;
        obs_err.delete();
        obs_xfers = 0; obs_seq_bad = 0; obs_run_cycles = 0; obs_stalls = 0;
        obs_hold_bad = 0; obs_busy_bad = 0; obs_gap = 0;
        obs_done = 0; obs_timeout = 0; obs_first_ok = 0; obs_aborted = 0;
        obs_after_ok = 0; obs_busy_done = 0; obs_rst_zero = 0;
        obs_root = 'x; obs_fail = 'x;
        stall_left = stall_len; finished = 0; prev_hold = 0; pulsed = 0;
        prev_idx = '0; prev_err = 1'b0; cyc = 0; rdy = 1'b1;
        @(negedge clk);
        sigma_in = sig; deg_in = deg; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs_first_ok = (out_valid === 1'b1) && (out_idx === 13'd0);
        while (!finished && cyc < LIMIT) begin
            start = 1'b0;
            if (done === 1'b1) begin
                obs_done      = 1;
                obs_root      = root_cnt;
                obs_fail      = fail;
                obs_busy_done = (busy === 1'b1) && (out_valid === 1'b0);
                @(negedge clk);
                obs_after_ok = (done === 1'b0) && (busy === 1'b0) && (out_valid === 1'b0)
                            && (fail === obs_fail) && (root_cnt === obs_root);
                finished = 1;
            end else if (out_valid === 1'b1) begin
                if (prev_hold && (out_idx !== prev_idx || out_err !== prev_err)) obs_hold_bad++;
                if (busy !== 1'b1) obs_busy_bad++;
                obs_run_cycles++;
                if (rst_idx >= 0 && int'(out_idx) == rst_idx) begin
                    rst_n = 1'b0;
                    #1;
                    obs_rst_zero = (busy === 1'b0) && (out_valid === 1'b0) && (done === 1'b0)
                                && (fail === 1'b0) && (root_cnt === 5'd0) && (out_err === 1'b0)
                                && (out_idx === 13'd0);
                    obs_aborted = 1;
                    finished = 1;
                end else begin
                    if (busy_idx >= 0 && int'(out_idx) == busy_idx && !pulsed) begin
                        start = 1'b1; sigma_in = ~sig; deg_in = deg ^ 4'h3; pulsed = 1;
                    end
                    case (mode)
                        0: rdy = 1'b1;
                        1: begin
                            if (int'(out_idx) == stall_idx && stall_left > 0) begin
                                rdy = 1'b0; stall_left--;
                            end else begin
                                rdy = 1'b1;
                            end
                        end
                        default: rdy = ($urandom_range(0, 9) != 0);
                    endcase
                    out_ready = rdy;
                    if (!rdy) begin
                        obs_stalls++;
                    end else begin
                        if (int'(out_idx) != obs_xfers) obs_seq_bad++;
                        if (out_err === 1'b1) obs_err.push_back(int'(out_idx));
                        obs_xfers++;
                    end
                    prev_hold = !rdy; prev_idx = out_idx; prev_err = out_err;
                    @(negedge clk);
                end
            end else begin
                obs_gap++; prev_hold = 0;
                @(negedge clk);
            end
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
        if (!finished) obs_timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, out_valid, done, fail, out_err} !== 5'b0 || root_cnt !== 5'd0 || out_idx !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b valid=%b done=%b fail=%b err=%b cnt=%0d idx=%0d, required all zero",
                     busy, out_valid, done, fail, out_err, root_cnt, out_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b valid=%b done=%b, required 0 0 0", busy, out_valid, done);
        end
    endtask

    task automatic test_single_root(input logic [3:0] deg, input logic exp_fail, input string tag);
        logic [SW-1:0] s;
        int            want [$];
        s = '0;
        s[0 +: M] = 13'd1;
        s[M +: M] = 13'(alog[8186]);
        want = '{5};
        run_search(s, deg, 0, -1, 0, -1, -1);
        vectors++;
        if (obs_timeout || !obs_done || !obs_first_ok) begin
            miscompares++;
            $display("FAIL %s_handshake: done=%0b first_ok=%0b timeout=%0b, required 1 1 0", tag, obs_done, obs_first_ok, obs_timeout);
        end
        vectors++;
        if (!same_list(obs_err, want)) begin
            miscompares++;
            $display("FAIL %s_err_pos: %0d flags first at %0d, required 1 flag at 5", tag, obs_err.size(), first_of(obs_err));
        end
        vectors++;
        if (obs_run_cycles != N_LEN || obs_seq_bad != 0 || obs_gap != 0) begin
            miscompares++;
            $display("FAIL %s_run_len: cycles=%0d seq_bad=%0d gap=%0d, required %0d 0 0", tag, obs_run_cycles, obs_seq_bad, obs_gap, N_LEN);
        end
        vectors++;
        if (obs_root !== 5'd1 || obs_fail !== exp_fail) begin
            miscompares++;
            $display("FAIL %s_verdict: root_cnt=%0d fail=%b, required 1 %b", tag, obs_root, obs_fail, exp_fail);
        end
        vectors++;
        if (obs_busy_bad != 0 || !obs_busy_done || !obs_after_ok) begin
            miscompares++;
            $display("FAIL %s_busy_done: busy_bad=%0d busy_done=%0b after_ok=%0b, required 0 1 1", tag, obs_busy_bad, obs_busy_done, obs_after_ok);
        end
    endtask

    task automatic test_two_roots();
        logic [SW-1:0] s;
        int            r [$];
        int            want [$];
        r = '{10, 4000};
        want = '{10, 4000};
        build_sigma(r, 1, s);
        run_search(s, 4'd2, 0, -1, 0, -1, -1);
        vectors++;
        if (obs_timeout || !same_list(obs_err, want)) begin
            miscompares++;
            $display("FAIL two_roots_err_pos: %0d flags first at %0d timeout=%0b, required flags at 10 and 4000", obs_err.size(), first_of(obs_err), obs_timeout);
        end
        vectors++;
        if (obs_root !== 5'd2 || obs_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL two_roots_verdict: root_cnt=%0d fail=%b, required 2 0", obs_root, obs_fail);
        end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] s;
        int            want [$];
        s = '0;
        s[0 +: M] = 13'd1;
        s[M +: M] = 13'(alog[8186]);
        want = '{5};
        run_search(s, 4'd1, 1, 5, 3, -1, -1);
        vectors++;
        if (obs_hold_bad != 0 || obs_stalls != 3 || obs_gap != 0) begin
            miscompares++;
            $display("FAIL stall_hold: hold_bad=%0d stalls=%0d gap=%0d, required 0 3 0", obs_hold_bad, obs_stalls, obs_gap);
        end
        vectors++;
        if (!same_list(obs_err, want) || obs_seq_bad != 0) begin
            miscompares++;
            $display("FAIL stall_emit_once: %0d flags first at %0d seq_bad=%0d, required 1 flag at 5", obs_err.size(), first_of(obs_err), obs_seq_bad);
        end
        vectors++;
        if (obs_timeout || obs_run_cycles != N_LEN + 3 || obs_root !== 5'd1 || obs_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done_delay: cycles=%0d cnt=%0d fail=%b, required %0d 1 0", obs_run_cycles, obs_root, obs_fail, N_LEN + 3);
        end
    endtask

    task automatic test_start_while_busy();
        logic [SW-1:0] s;
        int            want [$];
        s = '0;
        s[0 +: M] = 13'd1;
        s[M +: M] = 13'(alog[8186]);
        want = '{5};
        run_search(s, 4'd1, 0, -1, 0, 100, -1);
        vectors++;
        if (obs_timeout || !same_list(obs_err, want) || obs_run_cycles != N_LEN || obs_seq_bad != 0) begin
            miscompares++;
            $display("FAIL busy_start_ignored: %0d flags first at %0d cycles=%0d seq_bad=%0d, required 1 flag at 5 over %0d", obs_err.size(), first_of(obs_err), obs_run_cycles, obs_seq_bad, N_LEN);
        end
        vectors++;
        if (obs_root !== 5'd1 || obs_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_verdict: root_cnt=%0d fail=%b, required 1 0", obs_root, obs_fail);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [SW-1:0] s;
        int            r [$];
        r = '{10, 4000};
        build_sigma(r, 1, s);
        run_search(s, 4'd2, 0, -1, 0, -1, 300);
        vectors++;
        if (!obs_aborted || !obs_rst_zero) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: aborted=%0b all_zero=%0b, required 1 1", obs_aborted, obs_rst_zero);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_single_root(4'd1, 1'b0, "after_reset");
    endtask

    task automatic test_random_roots();
        logic [SW-1:0] s;
        int            r [$];
        int            k, cand, scalar;
        bit            dup;
        k = $urandom_range(1, T);
        while (r.size() < k) begin
            cand = $urandom_range(0, N_LEN - 1);
            dup = 0;
            foreach (r[q]) if (r[q] == cand) dup = 1;
            if (!dup) r.push_back(cand);
        end
        scalar = $urandom_range(1, NZ);
        build_sigma(r, scalar, s);
        model_roots(s);
        run_search(s, 4'(k), 2, -1, 0, -1, -1);
        vectors++;
        if (obs_timeout || !same_list(obs_err, exp_q) || obs_seq_bad != 0) begin
            miscompares++;
            $display("FAIL random_err_pos: %0d flags first at %0d seq_bad=%0d, required %0d flags first at %0d", obs_err.size(), first_of(obs_err), obs_seq_bad, exp_q.size(), first_of(exp_q));
        end
        vectors++;
        if (obs_run_cycles != N_LEN + obs_stalls || obs_hold_bad != 0) begin
            miscompares++;
            $display("FAIL random_throughput: cycles=%0d hold_bad=%0d, required %0d 0", obs_run_cycles, obs_hold_bad, N_LEN + obs_stalls);
        end
        vectors++;
        if (int'(obs_root) != exp_q.size() || obs_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL random_verdict: root_cnt=%0d fail=%b, required %0d 0", obs_root, obs_fail, exp_q.size());
        end
    endtask

    task automatic test_all_zero();
        logic [SW-1:0] s;
        logic [3:0]    d;
        s = '0;
        d = 4'($urandom_range(0, T));
        model_roots(s);
        run_search(s, d, 0, -1, 0, -1, -1);
        vectors++;
        if (obs_timeout || !same_list(obs_err, exp_q)) begin
            miscompares++;
            $display("FAIL zero_sigma_flags: %0d flags, required %0d", obs_err.size(), exp_q.size());
        end
        vectors++;
        if (obs_root !== 5'd31 || obs_fail !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_sigma_saturate: root_cnt=%0d fail=%b, required 31 1", obs_root, obs_fail);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        init_tables();
        test_reset();
        test_single_root(4'd1, 1'b0, "single");
        test_two_roots();
        test_single_root(4'd2, 1'b1, "deg_mismatch");
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_run();
        test_random_roots();
        test_all_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
